// File: rtl/time_entry_loader.sv
// rtl/time_entry_loader.sv - keypad time entry buffer that loads a BCD m:ss time into a countdown counter
module time_entry_loader #(
  parameter logic [3:0] MAX_DS = 4'd5
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [9:0] keypad,
  input  logic       start,
  input  logic       cancel,
  output logic [3:0] data,
  output logic       load,
  output logic [3:0] disp_m,
  output logic [3:0] disp_ds,
  output logic [3:0] disp_us,
  output logic       busy,
  output logic       ready,
  output logic       entry_err
);

  typedef enum logic [2:0] {IDLE, ENTRY, LOAD_M, LOAD_DS, LOAD_US, DONE} state_t;

  state_t     state;
  logic [9:0] prev_keypad;
  logic       prev_start;
  logic       prev_cancel;

  logic       key_rise;
  logic       key_one;
  logic [3:0] key_bcd;
  logic       start_rise;
  logic       cancel_rise;
  logic       start_ok;

  always_comb begin
    key_rise    = (keypad != 10'd0) && (prev_keypad == 10'd0);
    key_one     = $onehot(keypad);
    start_rise  = start && !prev_start;
    cancel_rise = cancel && !prev_cancel;
    // A zero time or a seconds-tens digit above MAX_DS is not a loadable time.
    start_ok    = (disp_ds <= MAX_DS) && ({disp_m, disp_ds, disp_us} != 12'd0);
    key_bcd     = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) key_bcd = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= IDLE;
      prev_keypad <= 10'd0;
      prev_start  <= 1'b0;
      prev_cancel <= 1'b0;
      disp_m      <= 4'd0;
      disp_ds     <= 4'd0;
      disp_us     <= 4'd0;
      data        <= 4'd0;
      load        <= 1'b0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      entry_err   <= 1'b0;
    end else begin
      prev_keypad <= keypad;
      prev_start  <= start;
      prev_cancel <= cancel;
      data        <= 4'd0;
      load        <= 1'b0;
      busy        <= 1'b0;
      entry_err   <= 1'b0;
      case (state)
        IDLE, ENTRY, DONE: begin
          // Priority: cancel, then key, then start.
          if (cancel_rise) begin
            disp_m  <= 4'd0;
            disp_ds <= 4'd0;
            disp_us <= 4'd0;
            ready   <= 1'b0;
            state   <= IDLE;
          end else if (key_rise) begin
            if (key_one) begin
              disp_m  <= disp_ds;
              disp_ds <= disp_us;
              disp_us <= key_bcd;
              ready   <= 1'b0;
              state   <= ENTRY;
            end else begin
              entry_err <= 1'b1;
            end
          end else if (start_rise && state != IDLE) begin
            if (start_ok) begin
              state <= LOAD_M;
              load  <= 1'b1;
              busy  <= 1'b1;
              data  <= disp_m;
              ready <= 1'b0;
            end else begin
              entry_err <= 1'b1;
            end
          end
        end
        LOAD_M: begin
          state <= LOAD_DS;
          load  <= 1'b1;
          busy  <= 1'b1;
          data  <= disp_ds;
        end
        LOAD_DS: begin
          state <= LOAD_US;
          load  <= 1'b1;
          busy  <= 1'b1;
          data  <= disp_us;
        end
        LOAD_US: begin
          state <= DONE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_entry_loader.sv
// tb/tb_time_entry_loader.sv - directed self-checking bench for time_entry_loader
module tb_time_entry_loader;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [9:0] keypad = 10'd0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] data;
  logic       load;
  logic [3:0] disp_m, disp_ds, disp_us;
  logic       busy, ready, entry_err;

  int errors = 0;
  int checks = 0;

  time_entry_loader #(.MAX_DS(4'd5)) dut (
    .clk(clk), .clear(clear), .keypad(keypad), .start(start), .cancel(cancel),
    .data(data), .load(load), .disp_m(disp_m), .disp_ds(disp_ds), .disp_us(disp_us),
    .busy(busy), .ready(ready), .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; keypad = 10'd0; start = 1'b0; cancel = 1'b0;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic press(input int k);
    keypad = 10'd1 << k;
    tick();
    keypad = 10'd0;
    tick();
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick();
    checks++; if ({load, busy, ready, entry_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {load, busy, ready, entry_err}); end
    checks++; if ({data, disp_m, disp_ds, disp_us} !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", {data, disp_m, disp_ds, disp_us}); end
    clear = 1'b0;
    tick();
  endtask

  task automatic test_load_sequence();
    do_clear();
    press(1); press(3); press(0);
    checks++; if ({disp_m, disp_ds, disp_us} !== 12'h130) begin errors++; $display("FAIL entry_130 got %h exp 130", {disp_m, disp_ds, disp_us}); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({load, busy, data} !== 6'b11_0001) begin errors++; $display("FAIL load_m got %b exp 110001", {load, busy, data}); end
    tick();
    checks++; if ({load, busy, data} !== 6'b11_0011) begin errors++; $display("FAIL load_ds got %b exp 110011", {load, busy, data}); end
    tick();
    checks++; if ({load, busy, data} !== 6'b11_0000) begin errors++; $display("FAIL load_us got %b exp 110000", {load, busy, data}); end
    tick();
    checks++; if ({load, busy, ready, data} !== 7'b001_0000) begin errors++; $display("FAIL done got %b exp 0010000", {load, busy, ready, data}); end
    checks++; if ({disp_m, disp_ds, disp_us} !== 12'h130) begin errors++; $display("FAIL done_buf got %h exp 130", {disp_m, disp_ds, disp_us}); end
  endtask

  task automatic test_bad_ds();
    int loads;
    do_clear();
    press(2); press(7); press(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({entry_err, load} !== 2'b10) begin errors++; $display("FAIL bad_ds_err got %b exp 10", {entry_err, load}); end
    loads = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (load || entry_err) loads++;
    end
    checks++; if (loads !== 0) begin errors++; $display("FAIL bad_ds_quiet got %0d exp 0", loads); end
    checks++; if ({disp_m, disp_ds, disp_us} !== 12'h275) begin errors++; $display("FAIL bad_ds_buf got %h exp 275", {disp_m, disp_ds, disp_us}); end
  endtask

  task automatic test_multi_key();
    do_clear();
    press(9); press(8); press(1); press(2);
    checks++; if ({disp_m, disp_ds, disp_us} !== 12'h812) begin errors++; $display("FAIL four_keys got %h exp 812", {disp_m, disp_ds, disp_us}); end
    keypad = 10'b0000000101;
    tick();
    checks++; if (entry_err !== 1'b1) begin errors++; $display("FAIL multi_err got %b exp 1", entry_err); end
    keypad = 10'd0;
    tick();
    checks++; if (entry_err !== 1'b0) begin errors++; $display("FAIL multi_err_pulse got %b exp 0", entry_err); end
    checks++; if ({disp_m, disp_ds, disp_us} !== 12'h812) begin errors++; $display("FAIL multi_buf got %h exp 812", {disp_m, disp_ds, disp_us}); end
  endtask

  task automatic test_zero_cancel();
    do_clear();
    press(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({entry_err, load} !== 2'b10) begin errors++; $display("FAIL zero_start got %b exp 10", {entry_err, load}); end
    tick();
    press(4);
    cancel = 1'b1; keypad = 10'd1 << 5;
    tick();
    cancel = 1'b0; keypad = 10'd0;
    checks++; if ({disp_m, disp_ds, disp_us} !== 12'h000) begin errors++; $display("FAIL cancel_buf got %h exp 000", {disp_m, disp_ds, disp_us}); end
    tick();
    // In IDLE a start edge is ignored: no error even though the buffer is zero.
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({entry_err, load, busy} !== 3'b000) begin errors++; $display("FAIL cancel_idle got %b exp 000", {entry_err, load, busy}); end
  endtask

  task automatic test_clear_in_load();
    int loads;
    do_clear();
    press(1); press(2); press(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if ({load, data} !== 5'b1_0010) begin errors++; $display("FAIL pre_clear got %b exp 10010", {load, data}); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if ({load, busy, disp_m, disp_ds, disp_us} !== 14'd0) begin errors++; $display("FAIL clear_abort got %h exp 0", {load, busy, disp_m, disp_ds, disp_us}); end
    loads = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (load || busy || ready) loads++;
    end
    checks++; if (loads !== 0) begin errors++; $display("FAIL clear_no_load got %0d exp 0", loads); end
  endtask

  task automatic test_done_key();
    do_clear();
    press(1); press(3); press(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL done_ready got %b exp 1", ready); end
    keypad = 10'd1 << 4;
    tick();
    checks++; if ({ready, disp_m, disp_ds, disp_us} !== 13'h0304) begin errors++; $display("FAIL done_key got %h exp 0304", {ready, disp_m, disp_ds, disp_us}); end
    for (int i = 0; i < 6; i++) tick();
    keypad = 10'd0;
    tick();
    checks++; if ({disp_m, disp_ds, disp_us} !== 12'h304) begin errors++; $display("FAIL held_key got %h exp 304", {disp_m, disp_ds, disp_us}); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    press(0); press(5); press(9);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({load, data} !== 5'b1_0000) begin errors++; $display("FAIL b2b_m got %b exp 10000", {load, data}); end
    tick();
    checks++; if ({load, data} !== 5'b1_0101) begin errors++; $display("FAIL b2b_ds got %b exp 10101", {load, data}); end
    tick();
    checks++; if ({load, data} !== 5'b1_1001) begin errors++; $display("FAIL b2b_us got %b exp 11001", {load, data}); end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({load, busy, ready, data} !== 7'b110_0000) begin errors++; $display("FAIL reload got %b exp 1100000", {load, busy, ready, data}); end
    tick(); tick(); tick();
    checks++; if ({load, busy, ready} !== 3'b001) begin errors++; $display("FAIL reload_done got %b exp 001", {load, busy, ready}); end
  endtask

  initial begin
    test_reset();
    test_load_sequence();
    test_bad_ds();
    test_multi_key();
    test_zero_cancel();
    test_clear_in_load();
    test_done_key();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
